// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a look-ahead sync_fifo in bursts onto a valid/ready stream.
// fifo_rd_en depends only on registered state and fifo_empty, never on m_ready.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclr,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_uw,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy
);
  localparam int RW = $clog2(BURST_LEN + 1);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int UW = ADDR_WIDTH + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [RW-1:0] remaining, remaining_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [1:0] occ, occ_nx;
  logic [1:0][DATA_WIDTH-1:0] buf_data, buf_data_nx;
  logic [1:0] buf_last, buf_last_nx;
  logic full_go, part_go, start, pop, pop_last, ret, wr_idx;
  always_comb begin
    full_go = fifo_uw >= UW'(BURST_LEN);
    part_go = fifo_uw != '0 && (flush || (TIMEOUT > 0 && tcnt == TW'(TIMEOUT)));
    start = state == IDLE && (full_go || part_go);
    pop = state == BURST && !fifo_empty && remaining != '0 && occ != 2'd2;
    pop_last = pop && remaining == RW'(1);
    ret = m_valid && m_ready;
    wr_idx = occ == 2'd1 && !ret;
    state_nx = sclr ? IDLE : start ? BURST : pop_last ? IDLE : state;
    remaining_nx = sclr ? '0 : start ? (full_go ? RW'(BURST_LEN) : RW'(fifo_uw))
                 : pop ? remaining - RW'(1) : remaining;
    tcnt_nx = (sclr || start || fifo_uw == '0) ? '0
            : (state == IDLE && fifo_uw < UW'(BURST_LEN) && tcnt != TW'(TIMEOUT)) ? tcnt + TW'(1)
            : tcnt;
    occ_nx = sclr ? 2'd0 : occ + {1'b0, pop} - {1'b0, ret};
    buf_data_nx = buf_data;
    buf_last_nx = buf_last;
    if (ret) begin
      buf_data_nx[0] = buf_data[1];
      buf_last_nx[0] = buf_last[1];
    end
    // A pop lands behind whatever survives this cycle's retire.
    if (pop) begin
      buf_data_nx[wr_idx] = fifo_data;
      buf_last_nx[wr_idx] = pop_last;
    end
    if (sclr) begin
      buf_data_nx = '0;
      buf_last_nx = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      remaining <= '0;
      tcnt <= '0;
      occ <= '0;
      buf_data <= '0;
      buf_last <= '0;
    end else begin
      state <= state_nx;
      remaining <= remaining_nx;
      tcnt <= tcnt_nx;
      occ <= occ_nx;
      buf_data <= buf_data_nx;
      buf_last <= buf_last_nx;
    end
  assign fifo_rd_en = pop;
  assign m_valid = occ != 2'd0;
  assign m_data = buf_data[0];
  assign m_last = m_valid && buf_last[0];
  assign busy = state == BURST || occ != 2'd0;
endmodule
